// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: holds the working registers a..h and the chaining value H0..H7,
// steps the round select 1..64, presents W0..W15 and folds the final a..h into the digest.
module sha256_round_ctrl #(
    parameter int ROUND_CYC = 2,
    parameter bit USE_IV    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   block_id,
    input  logic [511:0] msg_block,
    input  logic [255:0] chain_in,
    input  logic [31:0]  t1_in,
    input  logic [31:0]  t2_in,
    output logic [31:0]  a_o,
    output logic [31:0]  b_o,
    output logic [31:0]  c_o,
    output logic [31:0]  d_o,
    output logic [31:0]  e_o,
    output logic [31:0]  f_o,
    output logic [31:0]  g_o,
    output logic [31:0]  h_o,
    output logic [31:0]  msg_word,
    output logic [6:0]   select,
    output logic [1:0]   block,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_ADD
    } state_t;

    localparam logic [2:0] CYC_LAST = 3'(ROUND_CYC - 1);

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Element 0 sits in the MSBs, so {H0..H7} and {a..h} map straight onto the buses.
    state_t            state_q, state_d;
    logic [0:7][31:0]  work_q, work_d;
    logic [0:7][31:0]  h_q, h_d;
    logic [0:7][31:0]  h_sum;
    logic [511:0]      msg_q, msg_d;
    logic [1:0]        blk_q, blk_d;
    logic [6:0]        select_q, select_d;
    logic [2:0]        cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [255:0]      digest_q, digest_d;

    logic [31:0]       w_words [0:15];
    logic [6:0]        sel_m1;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_words
            assign w_words[gi] = msg_q[511-32*gi -: 32];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_sum
            assign h_sum[gi] = h_q[gi] + work_q[gi];
        end
    endgenerate

    assign sel_m1 = select_q - 7'd1;

    always_comb begin
        msg_word = 32'd0;
        if (select_q >= 7'd1 && select_q <= 7'd16) begin
            msg_word = w_words[sel_m1[3:0]];
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        h_d      = h_q;
        msg_d    = msg_q;
        blk_d    = blk_q;
        select_d = select_q;
        cyc_d    = cyc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        digest_d = digest_q;
        case (state_q)
            ST_IDLE: begin
                // The cycle in which done is high still belongs to the finishing block.
                if (start && !done_q) begin
                    msg_d   = msg_block;
                    blk_d   = block_id;
                    h_d     = USE_IV ? IV : chain_in;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                work_d   = h_q;
                select_d = 7'd1;
                cyc_d    = 3'd0;
                state_d  = ST_ROUND;
            end
            ST_ROUND: begin
                if (cyc_q == CYC_LAST) begin
                    work_d = {t1_in, work_q[0], work_q[1], work_q[2],
                              t2_in, work_q[4], work_q[5], work_q[6]};
                    cyc_d  = 3'd0;
                    if (select_q == 7'd64) begin
                        select_d = 7'd0;
                        state_d  = ST_ADD;
                    end else begin
                        select_d = select_q + 7'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            ST_ADD: begin
                h_d      = h_sum;
                digest_d = h_sum;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            h_q      <= '0;
            msg_q    <= '0;
            blk_q    <= 2'd0;
            select_q <= 7'd0;
            cyc_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            h_q      <= h_d;
            msg_q    <= msg_d;
            blk_q    <= blk_d;
            select_q <= select_d;
            cyc_q    <= cyc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digest_q <= digest_d;
        end
    end

    assign a_o    = work_q[0];
    assign b_o    = work_q[1];
    assign c_o    = work_q[2];
    assign d_o    = work_q[3];
    assign e_o    = work_q[4];
    assign f_o    = work_q[5];
    assign g_o    = work_q[6];
    assign h_o    = work_q[7];
    assign select = select_q;
    assign block  = blk_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign digest = digest_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a full SHA-256 round datapath model drives one instance (IV mode),
// a constant-1 stub drives a second (chain_in mode, 3 clocks per round).
module tb_sha256_round_ctrl;

    localparam int RC1 = 2;
    localparam int RC2 = 3;

    localparam logic [255:0] IV_REF  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic [31:0] K [0:64-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start1, start2;
    logic [1:0]   bid1, bid2;
    logic [511:0] msg1, msg2;
    logic [255:0] chain1, chain2;
    logic [31:0]  t1_1, t2_1, t1_2, t2_2;
    logic [31:0]  a1, b1, c1, d1, e1, f1, g1, h1, mw1;
    logic [31:0]  a2, b2, c2, d2, e2, f2, g2, h2, mw2;
    logic [6:0]   sel1, sel2;
    logic [1:0]   blk1, blk2;
    logic         busy1, busy2, done1, done2;
    logic [255:0] dig1, dig2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUND_CYC(RC1), .USE_IV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .block_id(bid1), .msg_block(msg1),
        .chain_in(chain1), .t1_in(t1_1), .t2_in(t2_1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .e_o(e1), .f_o(f1), .g_o(g1), .h_o(h1),
        .msg_word(mw1), .select(sel1), .block(blk1), .busy(busy1), .done(done1), .digest(dig1)
    );

    sha256_round_ctrl #(.ROUND_CYC(RC2), .USE_IV(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .block_id(bid2), .msg_block(msg2),
        .chain_in(chain2), .t1_in(t1_2), .t2_in(t2_2),
        .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2), .e_o(e2), .f_o(f2), .g_o(g2), .h_o(h2),
        .msg_word(mw2), .select(sel2), .block(blk2), .busy(busy2), .done(done2), .digest(dig2)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Message schedule word idx (0..63) of a 512-bit block.
    function automatic logic [31:0] sched(input logic [511:0] blk, input int idx);
        logic [31:0] w [0:63];
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
        return w[idx];
    endfunction

    // One compression round: returns {new a, new e}.
    function automatic logic [63:0] rnd(input logic [31:0] a, b, c, d, e, f, g, h, k, w);
        logic [31:0] tt1, tt2;
        tt1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        tt2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {tt1 + tt2, d + tt1};
    endfunction

    // Full single-block compression, independent of any controller timing.
    function automatic logic [255:0] sha_ref(input logic [511:0] blk, input logic [255:0] hin);
        logic [31:0]  v [0:7];
        logic [31:0]  hv [0:7];
        logic [63:0]  r;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255-32*i -: 32];
            v[i]  = hv[i];
        end
        for (int i = 0; i < 64; i++) begin
            r = rnd(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], K[i], sched(blk, i));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[0] = r[63:32];
            v[4] = r[31:0];
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hv[i] + v[i];
        return res;
    endfunction

    // Datapath model for dut1: captures W0..W15 as presented, expands the rest itself.
    logic [511:0] wcap1 = '0;
    int           kidx1;
    logic [31:0]  wt1;
    always @(posedge clk) begin
        if (sel1 >= 7'd1 && sel1 <= 7'd16) wcap1[511-32*(int'(sel1)-1) -: 32] <= mw1;
    end
    always_comb begin
        kidx1 = (sel1 == 7'd0) ? 0 : int'(sel1) - 1;
        wt1   = (sel1 <= 7'd16) ? mw1 : sched(wcap1, kidx1);
        {t1_1, t2_1} = rnd(a1, b1, c1, d1, e1, f1, g1, h1, K[kidx1], wt1);
    end

    assign t1_2 = 32'd1;
    assign t2_2 = 32'd1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called one step after the accepting edge (sample c=1); returns c at which done is seen.
    task automatic wait1(input bit trace, input logic [511:0] blk, input logic [1:0] id, output int lat);
        int          c;
        logic [6:0]  es;
        logic [31:0] em;
        lat = -1;
        for (c = 1; c < 400; c++) begin
            if (trace) begin
                es = (c >= 2 && c <= 1 + 64*RC1) ? 7'((c - 2) / RC1 + 1) : 7'd0;
                em = (es >= 7'd1 && es <= 7'd16) ? blk[511-32*(int'(es)-1) -: 32] : 32'd0;
                chk($sformatf("sel@%0d", c), sel1, es);
                chk($sformatf("mw@%0d", c), mw1, em);
                if (c == 2) chk("block_out", blk1, id);
                if (c == 1) chk("busy_start", busy1, 1'b1);
            end
            if (done1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) chk("timeout1", 1'b1, 1'b0);
    endtask

    task automatic run1(input logic [511:0] blk, input logic [1:0] id, input bit trace, input bit spam,
                        output logic [255:0] dig, output int lat);
        msg1   = blk;
        bid1   = id;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = spam;
        if (!spam) msg1 = {16{$urandom}};
        wait1(trace, blk, id, lat);
        dig = dig1;
    endtask

    task automatic run2(input logic [255:0] ch, output logic [255:0] dig, output int lat);
        chain2 = ch;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat    = -1;
        for (int c = 1; c < 600; c++) begin
            if (done2) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) chk("timeout2", 1'b1, 1'b0);
        dig = dig2;
    endtask

    logic [511:0] abc_blk, rblk;
    logic [255:0] dg, ch, exp_ch;
    int           lat;
    bit           hit;

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        rst_n = 1'b0; start1 = 1'b1; start2 = 1'b1;
        bid1 = 2'd0; bid2 = 2'd0; msg1 = '0; msg2 = '0; chain1 = '0; chain2 = '0;

        // Reset held with start asserted: everything stays quiet.
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_busy", {busy2, busy1}, 2'b00);
            chk("rst_done", {done2, done1}, 2'b00);
            chk("rst_sel", {sel2, sel1}, 14'd0);
            chk("rst_dig1", dig1, 256'd0);
            chk("rst_dig2", dig2, 256'd0);
        end
        start1 = 1'b0; start2 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc" with full select/msg_word trace; 131 clocks from accepting edge to done.
        run1(abc_blk, 2'd2, 1'b1, 1'b0, dg, lat);
        chk("abc_digest", dg, ABC_DIG);
        chk("abc_latency", 32'(lat), 32'd131);
        chk("abc_busy_done", busy1, 1'b0);
        @(posedge clk); #1;
        chk("done_width", done1, 1'b0);
        chk("digest_hold", dig1, ABC_DIG);

        // Random blocks against the standalone compression model.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom;
            run1(rblk, 2'($urandom_range(0, 3)), 1'b0, 1'b0, dg, lat);
            chk($sformatf("rand%0d_digest", n), dg, sha_ref(rblk, IV_REF));
            chk($sformatf("rand%0d_latency", n), 32'(lat), 32'd131);
            @(posedge clk); #1;
        end

        // Start held high through a whole block: one done, same digest, restart one cycle later.
        run1(abc_blk, 2'd1, 1'b0, 1'b1, dg, lat);
        chk("spam_digest", dg, ABC_DIG);
        chk("spam_latency", 32'(lat), 32'd131);
        @(posedge clk); #1;
        chk("spam_ignored_on_done", busy1, 1'b0);
        @(posedge clk); #1;
        chk("spam_accepted_after", busy1, 1'b1);
        start1 = 1'b0;
        wait1(1'b0, abc_blk, 2'd1, lat);
        chk("spam2_digest", dig1, ABC_DIG);
        chk("spam2_latency", 32'(lat), 32'd131);
        @(posedge clk); #1;

        // Reset in round 30, then a fresh run.
        msg1 = abc_blk; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (sel1 == 7'd30) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_round30", hit, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", sel1, 7'd0);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_digest", dig1, 256'd0);
        chk("mid_rst_regs", {a1, e1, h1}, 96'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run1(abc_blk, 2'd0, 1'b0, 1'b0, dg, lat);
        chk("post_rst_digest", dg, ABC_DIG);

        // Chaining instance with constant-1 datapath: each word becomes chain+1 mod 2^32.
        run2({8{32'hFFFFFFFF}}, dg, lat);
        chk("chain_wrap", dg, 256'd0);
        chk("chain_latency", 32'(lat), 32'(3 + 64*RC2));
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 8; i++) begin
                ch[255-32*i -: 32]     = $urandom;
                exp_ch[255-32*i -: 32] = ch[255-32*i -: 32] + 32'd1;
            end
            run2(ch, dg, lat);
            chk($sformatf("chain%0d_digest", n), dg, exp_ch);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
